// File: rtl/counter_ctrl_updown_if.sv
// Control/status bundle between the counter sequencer and whatever drives it.
// The master side (board glue or a testbench) drives the run/pause/load controls
// and the preload switches. The slave side (the sequencer) returns the count and status.
interface counter_ctrl_updown_if #(
    parameter int N = 10
);
    logic         start;
    logic         stop;
    logic         load;
    logic         up_down;
    logic [N-1:0] switches;
    logic [N-1:0] count;
    logic         tick;
    logic         running;
    logic         at_limit;

    modport master (
        output start, stop, load, up_down, switches,
        input  count, tick, running, at_limit
    );

    modport slave (
        input  start, stop, load, up_down, switches,
        output count, tick, running, at_limit
    );
endinterface

// File: rtl/counter_ctrl_updown.sv
// Up/down counter sequencer for the BCD display chain.
// A prescaler divides clk down to a count tick. The count feeds the 7-segment decoder.
// Control is IDLE/RUN/PAUSE with load > stop > start priority.
// Optional macro CNT_WRAP_EN makes the count wrap at its limits.
// When the macro is not defined, the count saturates at its limits.
module counter_ctrl_updown #(
    parameter int N         = 10,
    parameter int MAX_COUNT = 999,
    parameter int DIV       = 50_000_000,
    parameter int DIV_W     = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_ctrl_updown_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [N-1:0]     MAX_VAL    = N'(MAX_COUNT);
    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] presc;
    logic [N-1:0]     count_q;
    logic             tick_q;
    logic [N-1:0]     load_val;
    logic [N-1:0]     step_val;
    logic             terminal;

    // A step happens on the last prescaler cycle of a RUN period, unless a load pre-empts it.
    assign terminal = (state == ST_RUN) && (presc == PRESC_LAST) && !bus.load;

    // Preload value is clamped so the count can never leave its legal range.
    always_comb begin
        load_val = bus.switches;
        if (bus.switches > MAX_VAL) begin
            load_val = MAX_VAL;
        end
    end

    // Next count value for a step, including the behaviour at either limit.
    always_comb begin
        step_val = count_q;
        if (bus.up_down) begin
            if (count_q == MAX_VAL) begin
`ifdef CNT_WRAP_EN
                step_val = '0;
`else
                step_val = MAX_VAL;
`endif
            end else begin
                step_val = count_q + N'(1);
            end
        end else begin
            if (count_q == '0) begin
`ifdef CNT_WRAP_EN
                step_val = MAX_VAL;
`else
                step_val = '0;
`endif
            end else begin
                step_val = count_q - N'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: load forces PAUSE, stop beats start, start only leaves IDLE/PAUSE.
    always_comb begin
        state_next = state;
        if (bus.load) begin
            state_next = ST_PAUSE;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.stop) begin
                        state_next = ST_PAUSE;
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        bus.running = (state == ST_RUN);
    end

    // Prescaler, count and tick. Every RUN cycle advances the prescaler, including one
    // that samples stop. PAUSE keeps the prescaler phase so that a resume continues it.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else if (bus.load) begin
            presc   <= '0;
            count_q <= load_val;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (terminal) begin
                        presc   <= '0;
                        count_q <= step_val;
                        tick_q  <= 1'b1;
                    end else begin
                        presc <= presc + DIV_W'(1);
                    end
                end
                ST_PAUSE: presc <= presc;
                default:  presc <= '0;
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.tick     = tick_q;
    assign bus.at_limit = (bus.up_down && (count_q == MAX_VAL)) ||
                          (!bus.up_down && (count_q == '0));

endmodule

// File: tb/tb_counter_ctrl_updown.sv
// Self-checking bench for counter_ctrl_updown (DIV=4, MAX_COUNT=999, N=10).
// The bench uses a vector table, hand-written corner sequences and random stimulus.
// Random stimulus is checked against a cycle-level behavioural model.
module tb_counter_ctrl_updown;

    localparam int N    = 10;
    localparam int MAXC = 999;
    localparam int DIVP = 4;
`ifdef CNT_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int UP_AFTER  = WRAP ? 0 : MAXC;
    localparam int DN_AFTER  = WRAP ? MAXC : 0;
    localparam bit LIM_AFTER = WRAP ? 1'b0 : 1'b1;

    typedef struct {
        bit rst, start, stop, load, up_down;
        int sw;
        int e_count;
        bit e_tick, e_run, e_lim;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Model of the counter: mode 0=idle 1=run 2=pause, phase = RUN cycles since last tick.
    int m_mode  = 0;
    int m_phase = 0;
    int m_count = 0;
    bit m_tick  = 1'b0;

    counter_ctrl_updown_if #(.N(N)) bus ();

    counter_ctrl_updown #(
        .N(N), .MAX_COUNT(MAXC), .DIV(DIVP), .DIV_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit s, bit p, bit l, bit ud, int sw,
                                int ec, bit et, bit er, bit el);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.load = l; v.up_down = ud; v.sw = sw;
        v.e_count = ec; v.e_tick = et; v.e_run = er; v.e_lim = el;
        return v;
    endfunction

    task automatic modelEdge(bit r, bit s, bit p, bit l, bit ud, int sw);
        if (r) begin
            m_mode = 0; m_phase = 0; m_count = 0; m_tick = 1'b0;
        end else if (l) begin
            m_count = (sw > MAXC) ? MAXC : sw;
            m_phase = 0; m_tick = 1'b0; m_mode = 2;
        end else begin
            m_tick = 1'b0;
            if (m_mode == 1) begin
                m_phase = m_phase + 1;
                if (m_phase == DIVP) begin
                    m_phase = 0;
                    m_tick  = 1'b1;
                    if (ud) m_count = WRAP ? (m_count + 1) % (MAXC + 1)
                                           : ((m_count == MAXC) ? MAXC : m_count + 1);
                    else    m_count = WRAP ? (m_count + MAXC) % (MAXC + 1)
                                           : ((m_count == 0) ? 0 : m_count - 1);
                end
                if (p) m_mode = 2;
            end else if (s && !p) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic applyStimulus(bit r, bit s, bit p, bit l, bit ud, int sw);
        rst          = r;
        bus.start    = s;
        bus.stop     = p;
        bus.load     = l;
        bus.up_down  = ud;
        bus.switches = N'(sw);
        modelEdge(r, s, p, l, ud, sw);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, int ec, bit et, bit er, bit el);
        checks++;
        if (bus.count !== N'(ec) || bus.tick !== et || bus.running !== er || bus.at_limit !== el) begin
            errors++;
            $display("[TB] FAIL %s: got count=%0d tick=%0b running=%0b at_limit=%0b, want count=%0d tick=%0b running=%0b at_limit=%0b",
                     name, bus.count, bus.tick, bus.running, bus.at_limit, ec, et, er, el);
        end
    endtask

    initial begin
        vec_t vecs[$];
        bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0;
        bus.up_down = 1'b1; bus.switches = '0;

        // Reset, start counting up, ticks every DIV cycles; then both limits.
        vecs.push_back(mk(1,0,0,0,1,0,    0,0,0,0));
        vecs.push_back(mk(1,0,0,0,1,0,    0,0,0,0));
        vecs.push_back(mk(0,1,0,0,1,0,    0,0,1,0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,0,    1,1,1,0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0,1,0, 1,0,1,0));
        vecs.push_back(mk(0,0,0,0,1,0,    2,1,1,0));
        vecs.push_back(mk(0,0,0,1,1,1023, MAXC,0,0,1));
        vecs.push_back(mk(0,1,0,0,1,0,    MAXC,0,1,1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0,1,0, MAXC,0,1,1));
        vecs.push_back(mk(0,0,0,0,1,0,    UP_AFTER,1,1,LIM_AFTER));
        vecs.push_back(mk(0,0,0,1,0,0,    0,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,    0,0,1,1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,1));
        vecs.push_back(mk(0,0,0,0,0,0,    DN_AFTER,1,1,LIM_AFTER));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].load,
                          vecs[i].up_down, vecs[i].sw);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tick,
                        vecs[i].e_run, vecs[i].e_lim);
        end

        // Pause keeps the prescaler phase: after a 6-cycle RUN, the resume ticks on its 2nd cycle.
        applyStimulus(1,0,0,0,1,0);
        applyStimulus(0,1,0,0,1,0);
        for (int k = 0; k < 5; k++) applyStimulus(0,0,0,0,1,0);
        applyStimulus(0,0,1,0,1,0);
        checkOutput("stop_pause", 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0,0,1,0,1,0);
        applyStimulus(0,0,1,0,1,0);
        checkOutput("pause_frozen", 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0,1,0,0,1,0);
        checkOutput("resume", 1, 1'b0, 1'b1, 1'b0);
        applyStimulus(0,0,0,0,1,0);
        checkOutput("resume_1", 1, 1'b0, 1'b1, 1'b0);
        applyStimulus(0,0,0,0,1,0);
        checkOutput("resume_tick", 2, 1'b1, 1'b1, 1'b0);

        // start+stop together in RUN pauses; a load on the terminal cycle wins over the step.
        applyStimulus(0,1,1,0,1,0);
        checkOutput("start_stop", 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(0,1,0,0,1,0);
        applyStimulus(0,0,0,0,1,0);
        applyStimulus(0,0,0,0,1,0);
        applyStimulus(0,0,0,1,1,5);
        checkOutput("load_terminal", 5, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of RUN with count=37.
        applyStimulus(0,0,0,1,1,36);
        applyStimulus(0,1,0,0,1,0);
        for (int k = 0; k < 3; k++) applyStimulus(0,0,0,0,1,0);
        applyStimulus(0,0,0,0,1,0);
        checkOutput("count37", 37, 1'b1, 1'b1, 1'b0);
        applyStimulus(0,0,0,0,1,0);
        applyStimulus(1,0,0,0,1,0);
        checkOutput("rst_midrun", 0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the behavioural model.
        for (int k = 0; k < 600; k++) begin
            bit r, s, p, l, ud;
            int sw;
            r  = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 15) == 0);
            p  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) == 0);
            ud = ($urandom_range(0, 3) != 0) ^ (k >= 300);
            case ($urandom_range(0, 3))
                0:       sw = $urandom_range(0, 2);
                1:       sw = $urandom_range(997, 1023);
                default: sw = $urandom_range(0, 1023);
            endcase
            applyStimulus(r, s, p, l, ud, sw);
            checkOutput("rand", m_count, m_tick, (m_mode == 1),
                        (ud && m_count == MAXC) || (!ud && m_count == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
